fetch_pc_gen: RTL
=================

Name: fetch_pc_gen

Overview:
- Fetch-stage next-PC generator and IF/ID prediction register.
- Drives if_addr to instruction memory and to the branch predictor.
- Consumes the predictor's one-cycle-late id_target/id_target_taken for the instruction now in ID, plus EX/WB redirects.
- Produces the ID-stage PC, valid and prediction fields that EX later uses to detect mispredicts.

Parameters:
RESET_PC, 32'h0000_2000, first fetch address after reset
CNT_W, 32, width of saturating performance counters

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset asserted)
id_stall  in  1  hold IF and ID registers this cycle
ex_redirect  in  1  EX detected mispredict; fetch from ex_redirect_pc
ex_redirect_pc  in  32  corrected PC from EX
wb_redirect  in  1  WB flush (trap/fence); fetch from wb_redirect_pc
wb_redirect_pc  in  32  flush target from WB
id_target  in  32  predictor target for instruction in ID
id_target_taken  in  1  predictor says instruction in ID is taken
if_addr  out  32  current fetch PC (imem read address, predictor lookup)
id_pc  out  32  PC of instruction in ID
id_valid  out  1  instruction in ID is architecturally live
id_pred_taken  out  1  prediction carried with ID instruction
id_pred_target  out  32  predicted target carried with ID instruction
pred_redirects  out  CNT_W  saturating count of predicted-taken redirects
ex_redirects  out  CNT_W  saturating count of EX redirects

Behaviour:
- Reset (rst=0, async): if_addr=RESET_PC; if_valid=0; id_valid=0; id_pc=0; id_pred_taken=0; id_pred_target=0; both counters=0.
- First cycle after release: the fetch at RESET_PC is issued and if_valid becomes 1.
- if_valid is an internal flag meaning the word fetched at if_addr is live.
- Next-PC priority, evaluated every cycle:
  1. wb_redirect: next = wb_redirect_pc.
  2. ex_redirect: next = ex_redirect_pc.
  3. id_stall: hold if_addr.
  4. pred = id_valid && id_target_taken: next = id_target.
  5. Otherwise: next = if_addr + 4, modulo 2^32. 32'hFFFF_FFFC wraps to 0.
- Redirect and predicted targets have bits [1:0] forced to 0.
- Redirect (WB or EX) applies regardless of id_stall:
  - id_valid <= 0.
  - if_valid <= 1 for the new address.
  - The in-flight fetch and the ID instruction are both squashed.
- Predicted taken (no redirect, no stall):
  - The word now in IF (sequential path) is dropped: id_valid <= 0.
  - ID fields still capture if_addr.
- Normal advance (no redirect, no stall, no pred):
  - id_pc <= if_addr; id_valid <= if_valid.
  - id_pred_taken <= 0; id_pred_target <= if_addr + 4.
- The prediction for an instruction appears in the cycle it sits in ID. id_pred_taken/id_pred_target are registered from the predictor outputs into a side register in that cycle. They are presented as combinational overrides: id_pred_taken = id_valid && id_target_taken and id_pred_target = id_target while the instruction remains in ID.
- Stall: if_addr, id_* and if_valid hold. The predictor holds its outputs under stall, so a prediction made during a stall takes effect on the first unstalled cycle.
- Simultaneous wb_redirect and ex_redirect: WB wins; ex_redirects does not increment.
- Counters:
  - pred_redirects increments on each cycle condition 4 fires.
  - ex_redirects increments on each cycle condition 2 fires.
  - Both saturate at all-ones and never wrap.
- Latency: redirect at cycle N gives if_addr = target at N+1 and id_valid for that target at N+2 (if unstalled).

Decomposition:
- Shared package fetch_pkg holds:
  - RESET_PC default and PC_INC=4.
  - Enum next_pc_sel_t {SEL_WB, SEL_EX, SEL_HOLD, SEL_PRED, SEL_SEQ}.
  - Alignment mask 32'hFFFF_FFFC.
- One sub-module: fetch_perf_counter, a CNT_W saturating counter with inc input. Instantiated twice.

Test Plan:
- Reset then release, no stimulus -> if_addr 2000,2004,2008; id_valid first 1 at cycle 2 with id_pc=2000.
- ID holds 2008 with id_target_taken=1, id_target=3000 -> next if_addr=3000; id_valid=0 for one cycle; pred_redirects=1.
- ex_redirect=1, ex_redirect_pc=4003, same cycle id_stall=1 -> if_addr=4000 next cycle; id_valid=0; ex_redirects=1.
- wb_redirect (pc 5000) and ex_redirect (pc 6000) together -> if_addr=5000; ex_redirects unchanged.
- id_stall high 3 cycles with id_target_taken=1, target 7000 -> if_addr frozen; 7000 issued on the first unstalled cycle.
- Force if_addr=FFFF_FFFC, advance -> 0000_0000. Preload counter at all-ones plus one ex_redirect -> stays all-ones. Assert rst mid-redirect -> immediate RESET_PC, all id_* cleared.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: reset vector, PC step,
// next-PC source encoding and the instruction alignment mask.
package fetch_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_2000;
    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] ALIGN_MASK       = 32'hFFFF_FFFC;

    // Listed in priority order, highest first.
    typedef enum logic [2:0] {
        SEL_WB,
        SEL_EX,
        SEL_HOLD,
        SEL_PRED,
        SEL_SEQ
    } next_pc_sel_t;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_perf_counter.sv
// Saturating event counter: counts inc pulses, sticks at all-ones.
module fetch_perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_ONE;
        end
    end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch-stage next-PC selection and IF/ID register, including the
// prediction fields handed to EX for mispredict detection.
module fetch_pc_gen
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_stall,
    input  logic             ex_redirect,
    input  logic [31:0]      ex_redirect_pc,
    input  logic             wb_redirect,
    input  logic [31:0]      wb_redirect_pc,
    input  logic [31:0]      id_target,
    input  logic             id_target_taken,
    output logic [31:0]      if_addr,
    output logic [31:0]      id_pc,
    output logic             id_valid,
    output logic             id_pred_taken,
    output logic [31:0]      id_pred_target,
    output logic [CNT_W-1:0] pred_redirects,
    output logic [CNT_W-1:0] ex_redirects
);

    logic         if_valid;
    logic         pred_taken_q;
    logic [31:0]  pred_target_q;
    logic         pred_fire;
    logic [31:0]  seq_pc;
    logic [31:0]  next_pc;
    next_pc_sel_t sel;

    assign pred_fire = id_valid && id_target_taken;
    assign seq_pc    = if_addr + PC_INC;

    // The cycle right after reset behaves like a hold: the reset-vector
    // fetch is issued without advancing.
    // NOTE: every combinational output gets a default first, so no latch is inferred.
    always_comb begin
        sel = SEL_SEQ;
        if (wb_redirect) begin
            sel = SEL_WB;
        end else if (ex_redirect) begin
            sel = SEL_EX;
        end else if (id_stall || !if_valid) begin
            sel = SEL_HOLD;
        end else if (pred_fire) begin
            sel = SEL_PRED;
        end
    end

    always_comb begin
        next_pc = seq_pc;
        case (sel)
            SEL_WB:   next_pc = align_pc(wb_redirect_pc);
            SEL_EX:   next_pc = align_pc(ex_redirect_pc);
            SEL_HOLD: next_pc = if_addr;
            SEL_PRED: next_pc = align_pc(id_target);
            default:  next_pc = seq_pc;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_addr       <= RESET_PC;
            if_valid      <= 1'b0;
            id_pc         <= '0;
            id_valid      <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= '0;
        end else begin
            case (sel)
                SEL_WB, SEL_EX: begin
                    if_addr  <= next_pc;
                    if_valid <= 1'b1;
                    id_valid <= 1'b0;
                end
                SEL_HOLD: begin
                    if (!id_stall) begin
                        if_valid <= 1'b1;
                    end
                    // The predictor holds under stall; keep a copy of its verdict.
                    if (id_valid) begin
                        pred_taken_q  <= id_target_taken;
                        pred_target_q <= align_pc(id_target);
                    end
                end
                SEL_PRED: begin
                    if_addr       <= next_pc;
                    id_pc         <= if_addr;
                    id_valid      <= 1'b0;
                    pred_taken_q  <= 1'b0;
                    pred_target_q <= seq_pc;
                end
                default: begin
                    if_addr       <= next_pc;
                    id_pc         <= if_addr;
                    id_valid      <= if_valid;
                    pred_taken_q  <= 1'b0;
                    pred_target_q <= seq_pc;
                end
            endcase
        end
    end

    // Live ID instructions see the predictor directly; otherwise the side register.
    assign id_pred_taken  = id_valid ? id_target_taken     : pred_taken_q;
    assign id_pred_target = id_valid ? align_pc(id_target) : pred_target_q;

    fetch_perf_counter #(.CNT_W(CNT_W)) u_pred_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (sel == SEL_PRED),
        .count (pred_redirects)
    );

    fetch_perf_counter #(.CNT_W(CNT_W)) u_ex_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (sel == SEL_EX),
        .count (ex_redirects)
    );

endmodule
